// File: rtl/com_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : com_bus_arbiter
// Description : Round-robin arbiter for the shared common bus of four caches.
//               Non-preemptive grants with a one-cycle turnaround between owners.
// Revision    : 1.0 - initial release
// ============================================================================

module com_bus_arbiter #(
    parameter int NUM_PROC  = 4,
    parameter int MAX_HOLD  = 64,
    parameter int CNT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PROC-1:0] Com_Bus_Req_proc,
    output logic [NUM_PROC-1:0] Com_Bus_Gnt_proc,
    output logic [1:0]          Bus_Owner,
    output logic                Bus_Busy,
    output logic                Hold_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_cnt_max  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_hold_lim = CNT_WIDTH'(MAX_HOLD - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_PROC-1:0]   r_gnt;
    logic [1:0]            r_owner;
    logic [CNT_WIDTH-1:0]  r_hold_cnt;
    logic                  r_hold_err;

    logic [1:0]            w_cand_idx [4];
    logic [3:0]            w_cand_req;
    logic [1:0]            w_winner;
    logic                  w_any_req;
    logic                  w_owner_req;
    logic                  w_new_grant;
    logic                  w_release;

    // Candidate j is owner+1+j (mod 4); the current owner is always searched last.
    genvar j;
    generate
        for (j = 0; j < 4; j++) begin : g_cand
            assign w_cand_idx[j] = r_owner + 2'(j + 1);
            assign w_cand_req[j] = Com_Bus_Req_proc[w_cand_idx[j]];
        end
    endgenerate

    always_comb begin
        w_winner = w_cand_idx[3];
        if (w_cand_req[2]) w_winner = w_cand_idx[2];
        if (w_cand_req[1]) w_winner = w_cand_idx[1];
        if (w_cand_req[0]) w_winner = w_cand_idx[0];
    end

    assign w_any_req   = |Com_Bus_Req_proc;
    assign w_owner_req = Com_Bus_Req_proc[r_owner];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_new_grant = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE, S_TURN: begin
                if (w_any_req) begin
                    w_state_nxt = S_GRANT;
                    w_new_grant = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GRANT: begin
                if (!w_owner_req) begin
                    w_state_nxt = S_TURN;
                    w_release   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt   <= '0;
            r_owner <= 2'd3;
        end else if (w_new_grant) begin
            r_gnt   <= NUM_PROC'(1) << w_winner;
            r_owner <= w_winner;
        end else if (w_release) begin
            r_gnt   <= '0;
        end
    end

    // Hold watchdog: counter restarts per grant; error is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
            r_hold_err <= 1'b0;
        end else begin
            if (w_new_grant) begin
                r_hold_cnt <= '0;
            end else if (r_state == S_GRANT && r_hold_cnt != c_cnt_max) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
            if (r_state == S_GRANT && w_owner_req && r_hold_cnt >= c_hold_lim) begin
                r_hold_err <= 1'b1;
            end
        end
    end

    assign Com_Bus_Gnt_proc = r_gnt;
    assign Bus_Owner        = r_owner;
    assign Bus_Busy         = |r_gnt;
    assign Hold_err         = r_hold_err;

endmodule

`default_nettype wire

// File: tb/tb_com_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_com_bus_arbiter
// Description : Directed vector bench for com_bus_arbiter (MAX_HOLD = 4).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_com_bus_arbiter;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       herr;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       herr;

    int n_vec;
    int n_fail;
    vec_t tbl[$];

    com_bus_arbiter #(
        .NUM_PROC (4),
        .MAX_HOLD (4),
        .CNT_WIDTH(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .Com_Bus_Req_proc(req),
        .Com_Bus_Gnt_proc(gnt),
        .Bus_Owner       (owner),
        .Bus_Busy        (busy),
        .Hold_err        (herr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g,
                       input logic [1:0] o, input logic h);
        vec_t v;
        v.rst = r; v.req = q; v.gnt = g; v.owner = o; v.herr = h;
        tbl.push_back(v);
    endtask

    task automatic step(input logic r, input logic [3:0] q);
        @(negedge clk);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] act,
                         input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [3:0] g, input logic [1:0] o,
                             input logic h);
        check("gnt",   idx, gnt,           g);
        check("owner", idx, {2'b00, owner}, {2'b00, o});
        check("busy",  idx, {3'b000, busy}, {3'b000, (g != 4'b0000)});
        check("herr",  idx, {3'b000, herr}, {3'b000, h});
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst    = 1'b1;
        req    = 4'b0000;

        // Reset, single requester held 5 cycles (hold error at 4), release
        add(1, 4'b0000, 4'b0000, 2'd3, 0);
        add(1, 4'b0000, 4'b0000, 2'd3, 0);
        add(0, 4'b0100, 4'b0100, 2'd2, 0);
        add(0, 4'b0100, 4'b0100, 2'd2, 0);
        add(0, 4'b0100, 4'b0100, 2'd2, 0);
        add(0, 4'b0100, 4'b0100, 2'd2, 0);
        add(0, 4'b0100, 4'b0100, 2'd2, 1);
        add(0, 4'b0000, 4'b0000, 2'd2, 1);
        add(0, 4'b0000, 4'b0000, 2'd2, 1);
        add(1, 4'b0000, 4'b0000, 2'd3, 0);
        // Fairness with all four requesting, 3 grant cycles each
        add(0, 4'b1111, 4'b0001, 2'd0, 0);
        add(0, 4'b1111, 4'b0001, 2'd0, 0);
        add(0, 4'b1111, 4'b0001, 2'd0, 0);
        add(0, 4'b1110, 4'b0000, 2'd0, 0);
        add(0, 4'b1111, 4'b0010, 2'd1, 0);
        add(0, 4'b1111, 4'b0010, 2'd1, 0);
        add(0, 4'b1111, 4'b0010, 2'd1, 0);
        add(0, 4'b1101, 4'b0000, 2'd1, 0);
        add(0, 4'b1111, 4'b0100, 2'd2, 0);
        add(0, 4'b1111, 4'b0100, 2'd2, 0);
        add(0, 4'b1111, 4'b0100, 2'd2, 0);
        add(0, 4'b1011, 4'b0000, 2'd2, 0);
        add(0, 4'b1111, 4'b1000, 2'd3, 0);
        add(0, 4'b1111, 4'b1000, 2'd3, 0);
        add(0, 4'b1111, 4'b1000, 2'd3, 0);
        add(0, 4'b0111, 4'b0000, 2'd3, 0);
        add(0, 4'b1111, 4'b0001, 2'd0, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0);
        // No preemption: cache 1 owns, cache 0 waits
        add(0, 4'b0010, 4'b0010, 2'd1, 0);
        add(0, 4'b0011, 4'b0010, 2'd1, 0);
        add(0, 4'b0011, 4'b0010, 2'd1, 0);
        add(0, 4'b0001, 4'b0000, 2'd1, 0);
        add(0, 4'b0001, 4'b0001, 2'd0, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0);
        // Sole re-requester, and a one-cycle grant
        add(0, 4'b0100, 4'b0100, 2'd2, 0);
        add(0, 4'b0000, 4'b0000, 2'd2, 0);
        add(0, 4'b0100, 4'b0100, 2'd2, 0);
        add(0, 4'b0000, 4'b0000, 2'd2, 0);
        add(0, 4'b0000, 4'b0000, 2'd2, 0);
        // Hold error: req 3 high for 6 edges
        add(0, 4'b1000, 4'b1000, 2'd3, 0);
        add(0, 4'b1000, 4'b1000, 2'd3, 0);
        add(0, 4'b1000, 4'b1000, 2'd3, 0);
        add(0, 4'b1000, 4'b1000, 2'd3, 0);
        add(0, 4'b1000, 4'b1000, 2'd3, 1);
        add(0, 4'b1000, 4'b1000, 2'd3, 1);
        add(0, 4'b0000, 4'b0000, 2'd3, 1);
        add(0, 4'b0000, 4'b0000, 2'd3, 1);
        add(0, 4'b0000, 4'b0000, 2'd3, 1);
        // Reset mid-grant with everyone requesting
        add(1, 4'b0000, 4'b0000, 2'd3, 0);
        add(0, 4'b0100, 4'b0100, 2'd2, 0);
        add(0, 4'b1111, 4'b0100, 2'd2, 0);
        add(1, 4'b1111, 4'b0000, 2'd3, 0);
        add(0, 4'b1111, 4'b0001, 2'd0, 0);
        add(0, 4'b1111, 4'b0001, 2'd0, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req);
            check_all(i, tbl[i].gnt, tbl[i].owner, tbl[i].herr);
        end

        // Lost request: cache 2 pulses while cache 1 owns the bus
        step(0, 4'b0010); check_all(100, 4'b0010, 2'd1, 0);
        step(0, 4'b0110); check_all(101, 4'b0010, 2'd1, 0);
        step(0, 4'b0010); check_all(102, 4'b0010, 2'd1, 0);
        step(0, 4'b0000); check_all(103, 4'b0000, 2'd1, 0);
        step(0, 4'b0000); check_all(104, 4'b0000, 2'd1, 0);
        step(0, 4'b0000); check_all(105, 4'b0000, 2'd1, 0);

        // Long hold past counter saturation: grant kept, error sticky
        for (int k = 0; k < 300; k++) step(0, 4'b0001);
        check_all(200, 4'b0001, 2'd0, 1);
        step(0, 4'b0001); check_all(201, 4'b0001, 2'd0, 1);
        step(0, 4'b0000); check_all(202, 4'b0000, 2'd0, 1);
        step(0, 4'b0010); check_all(203, 4'b0010, 2'd1, 1);
        step(1, 4'b0010); check_all(204, 4'b0000, 2'd3, 0);
        step(0, 4'b0010); check_all(205, 4'b0010, 2'd1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/com_bus_arbiter.md
# com_bus_arbiter

Round-robin arbiter for the shared common (snoop/memory) bus that connects the four per-core cache units. It samples each cache's `Com_Bus_Req_proc` and returns a one-hot `Com_Bus_Gnt_proc`, which authorises exactly one cache at a time to drive `Address_Com`/`Data_Bus_Com`/`Data_in_Bus`. A grant is held until the owner drops its request. Ownership changes only through a one-cycle bus turnaround so tri-stated drivers never overlap.

## Interface
- `NUM_PROC`, 4, number of requesting caches; the design is fixed at 4, with a 2-bit owner ID.
- `MAX_HOLD`, 64, grant-hold cycle count at which `Hold_err` is raised.
- `CNT_WIDTH`, 8, width of the hold counter; must satisfy 2^CNT_WIDTH > MAX_HOLD.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Com_Bus_Req_proc`  in  4  bit i = bus request from cache i; level, held high for the whole transaction.
- `Com_Bus_Gnt_proc`  out  4  one-hot grant; bit i feeds cache i's `Com_Bus_Gnt_proc`.
- `Bus_Owner`  out  2  index of the current grantee; holds the last grantee when idle.
- `Bus_Busy`  out  1  high while any grant is asserted.
- `Hold_err`  out  1  sticky flag: some grant was held for ≥ MAX_HOLD cycles.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one owner.
  - TURN: one dead cycle after a release.
- IDLE:
  - If any request bit is high at the edge, pick a winner, set its `Com_Bus_Gnt_proc` bit, load `Bus_Owner`, and go to GRANT.
  - Otherwise stay in IDLE.
- Winner selection is round-robin from `Bus_Owner`. Search order is owner+1, owner+2, owner+3, owner (mod 4); the first set bit wins.
- GRANT:
  - While `Com_Bus_Req_proc[Bus_Owner]` is high, the grant is held. Requests from other caches are ignored; there is no preemption.
  - When the owner's request is sampled low: clear the grant, go to TURN. `Bus_Owner` keeps its value.
- TURN:
  - Grant stays all-zero for this cycle.
  - At the exit edge, apply the same selection as IDLE. If a request is pending, go directly to GRANT with the new winner; otherwise go to IDLE.
  - The previous owner has lowest priority in this selection. It is re-granted only if it is the sole requester.
- Hold counter:
  - Cleared on every new grant.
  - Increments each cycle in GRANT and saturates at 2^CNT_WIDTH−1.
  - When the counter reaches MAX_HOLD−1 while the grant continues, `Hold_err` is set on the next edge.
  - `Hold_err` is cleared only by `rst`. Exceeding MAX_HOLD does not revoke the grant.
- Invariants:
  - `Com_Bus_Gnt_proc` is always zero or one-hot.
  - `Bus_Busy` == |`Com_Bus_Gnt_proc`.
  - A set grant bit always equals bit `Bus_Owner`.

## Timing
- Reset values:
  - state = IDLE
  - `Com_Bus_Gnt_proc` = 4'b0000
  - `Bus_Owner` = 2'd3, so cache 0 has highest priority after reset
  - `Bus_Busy` = 0
  - `Hold_err` = 0
  - hold counter = 0
- `rst` takes priority over every other event, including mid-grant. The grant drops at the same edge and the next arbitration happens no earlier than the first edge after `rst` is deasserted.
- Request-to-grant latency from IDLE: request high before edge k → grant visible after edge k (1 cycle).
- Release-to-next-grant:
  - Owner request sampled low at edge k → grant cleared after edge k.
  - TURN occupies cycle k..k+1.
  - Next grant is visible after edge k+1.
  - Exactly one cycle with all grants low between owners.
- A request that rises and falls before being granted is lost. Requesters must hold their request until granted.
- If the owner's request is already low at the edge right after its grant, the grant lasts exactly 1 cycle and is followed by TURN.
- Simultaneous events are resolved by the fixed rules above:
  - release and new request in the same cycle: TURN still occurs;
  - all four requesting: round-robin order.

## Test plan
- Reset then single requester: `rst` high for 2 cycles. Raise req=4'b0100 at cycle 3 → `Com_Bus_Gnt_proc`=4'b0100 and `Bus_Owner`=2 after the next edge, `Bus_Busy`=1. Hold the request for 5 cycles → grant stays for 5 cycles. Drop the request → grant clears next cycle.
- Fairness: hold req=4'b1111 continuously, with each owner releasing after 3 grant cycles → grant sequence 0,1,2,3,0. Exactly one all-zero cycle between consecutive grants.
- No preemption: cache 1 owns the bus; raise req 0 mid-transaction → grant 1 is unaffected. Cache 1 drops → one TURN cycle, then grant 0.
- Sole re-requester: cache 2 releases and re-raises its request immediately, with no other requests → a TURN cycle, then `Com_Bus_Gnt_proc`=4'b0100 again.
- Hold error: MAX_HOLD=4; keep req 3 high for 6 cycles → `Hold_err` rises after the 4th grant cycle and the grant is not revoked. `Hold_err` stays 1 after release until `rst`.
- Reset mid-grant: assert `rst` while cache 2 owns the bus, with all requests high → grant is 0 after the `rst` edge and `Bus_Owner`=3. On the first edge after `rst` deasserts, cache 0 is granted.
